// File: rtl/rr_merge2_1_pkg.sv
// rr_merge2_1_pkg: shared port-index convention and grant helper for the 2:1 merge
package rr_merge2_1_pkg;
   localparam int PORT_LO = 0;
   localparam int PORT_HI = 1;
   function automatic logic pick_port(input logic [1:0] nonempty, input logic rr_ptr);
      return (nonempty[PORT_LO] & nonempty[PORT_HI]) ? rr_ptr : nonempty[PORT_HI];
   endfunction
endpackage

// File: rtl/rr_merge2_1_fifo.sv
// fifo_sync: single-clock FIFO, no empty or full bypass, async active-high reset
module fifo_sync #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic do_push, do_pop;
   assign full    = count == CW'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   // storage array carries no reset; count and pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
   // pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/rr_merge2_1_mux.sv
// mux_comb2_1: combinational 2:1 select of a packed pair, zero when not enabled
module mux_comb2_1 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    i_cmd,
   input  logic                    i_en,
   input  logic                    i_valid,
   input  logic [2*DATA_WIDTH-1:0] i_data_bus,
   output logic                    o_valid,
   output logic [DATA_WIDTH-1:0]   o_data_bus
);
   assign o_valid    = i_en & i_valid;
   assign o_data_bus = !o_valid ? '0 :
                       i_cmd ? i_data_bus[DATA_WIDTH+:DATA_WIDTH] : i_data_bus[0+:DATA_WIDTH];
endmodule

// File: rtl/rr_merge2_1.sv
// rr_merge2_1: buffered round-robin 2:1 merge with a one-entry output register
module rr_merge2_1
   import rr_merge2_1_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              i_valid,
   input  logic [2*DATA_WIDTH-1:0] i_data_bus,
   output logic [1:0]              o_ready,
   input  logic                    i_en,
   output logic                    o_valid,
   output logic [DATA_WIDTH-1:0]   o_data_bus,
   input  logic                    i_ready
);
   logic [1:0] full, empty, nonempty, push, pop;
   logic [2*DATA_WIDTH-1:0] heads;
   logic [DATA_WIDTH-1:0] sel_data;
   logic grant, load, sel_valid, rr_ptr;
   assign nonempty = ~empty;
   assign o_ready  = ~full & {2{~rst}};
   assign push     = i_valid & o_ready;
   assign grant    = pick_port(nonempty, rr_ptr);
   assign load     = i_en & (~o_valid | i_ready) & (|nonempty);
   assign pop      = {load & grant, load & ~grant};
   for (genvar k = 0; k < 2; k++) begin : g_fifo
      fifo_sync #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[k]),
         .pop   (pop[k]),
         .wdata (i_data_bus[k*DATA_WIDTH+:DATA_WIDTH]),
         .full  (full[k]),
         .empty (empty[k]),
         .head  (heads[k*DATA_WIDTH+:DATA_WIDTH])
      );
   end
   mux_comb2_1 #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
      .i_cmd      (grant),
      .i_en       (load),
      .i_valid    (1'b1),
      .i_data_bus (heads),
      .o_valid    (sel_valid),
      .o_data_bus (sel_data)
   );
   // output register: load the granted head, otherwise clear once the consumer takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid    <= 1'b0;
         o_data_bus <= '0;
         rr_ptr     <= 1'b0;
      end else if (sel_valid) begin
         o_valid    <= 1'b1;
         o_data_bus <= sel_data;
         rr_ptr     <= ~grant;
      end else if (o_valid & i_ready) begin
         o_valid    <= 1'b0;
         o_data_bus <= '0;
      end
   end
endmodule

// File: tb/tb_rr_merge2_1.sv
// tb_rr_merge2_1: randomized and directed checks of rr_merge2_1 against a queue model
module tb_rr_merge2_1;
   localparam int W = 32;
   localparam int D = 2;
   logic clk, rst, i_en, i_ready, o_valid;
   logic [1:0] i_valid, o_ready;
   logic [2*W-1:0] i_data_bus;
   logic [W-1:0] o_data_bus;
   rr_merge2_1 #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .o_ready(o_ready),
      .i_en(i_en), .o_valid(o_valid), .o_data_bus(o_data_bus), .i_ready(i_ready)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   logic [W-1:0] q0[$], q1[$], log_q[$];
   logic m_valid = 0, m_rr = 0;
   logic [W-1:0] m_data = 0;
   // reference model: two bounded queues, an output slot and a preferred-port bit
   always @(posedge clk or posedge rst) begin
      logic acc0, acc1, ne0, ne1, ld, g;
      if (rst) begin
         q0.delete();
         q1.delete();
         m_valid = 0;
         m_data = 0;
         m_rr = 0;
      end else begin
         acc0 = i_valid[0] && q0.size() < D;
         acc1 = i_valid[1] && q1.size() < D;
         ne0 = q0.size() != 0;
         ne1 = q1.size() != 0;
         ld = i_en && (!m_valid || i_ready) && (ne0 || ne1);
         g = (ne0 && ne1) ? m_rr : ne1;
         if (ld) begin
            m_data = g ? q1.pop_front() : q0.pop_front();
            m_valid = 1;
            m_rr = !g;
         end else if (m_valid && i_ready) begin
            m_valid = 0;
            m_data = 0;
         end
         if (acc0) q0.push_back(i_data_bus[0+:W]);
         if (acc1) q1.push_back(i_data_bus[W+:W]);
      end
   end
   // per-cycle comparison against the model, plus a log of words handed downstream
   always @(negedge clk) begin
      logic [1:0] er;
      er = rst ? 2'b00 : {q1.size() < D, q0.size() < D};
      checks++;
      if (o_valid !== m_valid || o_data_bus !== m_data || o_ready !== er) begin
         failures++;
         $display("FAIL model t=%0t valid=%b/%b data=%h/%h ready=%b/%b", $time,
                  o_valid, m_valid, o_data_bus, m_data, o_ready, er);
      end
      if (!rst && o_valid && i_ready) log_q.push_back(o_data_bus);
   end
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic rst_pulse();
      @(posedge clk);
      #1 rst = 1;
      tick(1);
      rst = 0;
   endtask
   initial begin
      int n0, n1;
      logic [1:0] a;
      rst = 0; i_valid = 0; i_data_bus = 0; i_en = 1; i_ready = 1;
      #1 rst = 1;
      @(negedge clk);
      chk("reset_ready", W'(o_ready), 0);
      chk("reset_valid", W'(o_valid), 0);
      chk("reset_data", o_data_bus, 0);
      tick(2);
      rst = 0;
      tick(1);
      chk("ready_after_release", W'(o_ready), 3);
      i_valid = 2'b01; i_data_bus = {32'h0, 32'hA5A5A5A5};
      tick(1);
      i_valid = 0;
      tick(1);
      chk("single_valid", W'(o_valid), 1);
      chk("single_data", o_data_bus, 32'hA5A5A5A5);
      tick(1);
      chk("single_drain_valid", W'(o_valid), 0);
      chk("single_drain_data", o_data_bus, 0);
      rst_pulse();
      log_q.delete();
      n0 = 0; n1 = 0;
      for (int c = 0; c < 40; c++) begin
         i_valid = 2'b11; i_data_bus = {32'h200 + n1, 32'h100 + n0};
         @(negedge clk);
         a = o_ready;
         tick(1);
         n0 += int'(a[0]); n1 += int'(a[1]);
      end
      i_valid = 0;
      tick(8);
      chk("fair_count", log_q.size(), n0 + n1);
      for (int j = 0; j < 16 && j < log_q.size(); j++)
         chk("fair_order", log_q[j], (j % 2) ? 32'h200 + j / 2 : 32'h100 + j / 2);
      log_q.delete();
      i_ready = 0; n1 = 0;
      for (int c = 0; c < 8; c++) begin
         i_valid = 2'b10; i_data_bus = {32'h300 + n1, 32'h0};
         @(negedge clk);
         a = o_ready;
         tick(1);
         n1 += int'(a[1]);
      end
      chk("bp_accepted", n1, 3);
      chk("bp_valid", W'(o_valid), 1);
      chk("bp_data", o_data_bus, 32'h300);
      chk("bp_full", W'(o_ready[1]), 0);
      i_ready = 1;
      for (int c = 0; c < 10 && n1 < 4; c++) begin
         i_valid = 2'b10; i_data_bus = {32'h300 + n1, 32'h0};
         @(negedge clk);
         a = o_ready;
         tick(1);
         n1 += int'(a[1]);
      end
      i_valid = 0;
      tick(6);
      chk("bp_count", log_q.size(), 4);
      for (int j = 0; j < 4 && j < log_q.size(); j++) chk("bp_order", log_q[j], 32'h300 + j);
      rst_pulse();
      log_q.delete();
      i_en = 0;
      i_valid = 2'b11; i_data_bus = {32'h500, 32'h400};
      tick(1);
      i_data_bus = {32'h501, 32'h401};
      tick(1);
      i_valid = 0;
      tick(4);
      chk("en_off_valid", W'(o_valid), 0);
      chk("en_off_ready", W'(o_ready), 0);
      i_en = 1;
      tick(8);
      chk("en_count", log_q.size(), 4);
      for (int j = 0; j < 4 && j < log_q.size(); j++)
         chk("en_order", log_q[j], (j % 2) ? 32'h500 + j / 2 : 32'h400 + j / 2);
      log_q.delete();
      i_ready = 0;
      i_valid = 2'b11; i_data_bus = {32'h700, 32'h600};
      tick(3);
      i_valid = 0;
      chk("mid_valid_before", W'(o_valid), 1);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("mid_valid", W'(o_valid), 0);
      chk("mid_data", o_data_bus, 0);
      chk("mid_ready", W'(o_ready), 0);
      @(posedge clk);
      #3 rst = 0;
      @(negedge clk);
      chk("mid_ready_after", W'(o_ready), 3);
      i_ready = 1;
      tick(5);
      chk("mid_no_stale", log_q.size(), 0);
      for (int c = 0; c < 3000; c++) begin
         i_valid = 2'($urandom);
         i_data_bus = {$urandom, $urandom};
         i_en = ($urandom % 8) != 0;
         i_ready = ($urandom % 4) != 0;
         tick(1);
      end
      i_valid = 0; i_en = 1; i_ready = 1;
      tick(8);
      chk("final_idle", W'(o_valid), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_merge2_1.md
Name: rr_merge2_1

Overview:
- Buffered, round-robin 2:1 merge stage for the reduction/collection path of the NoC.
- Each of two input ports feeds a private FIFO with valid/ready backpressure.
- An arbiter picks a non-empty FIFO and forwards its head through the 2:1 select into a one-entry output register with a valid/ready handshake toward the downstream consumer.
- Packing matches the 2:1 mux convention: low half is input 0, high half is input 1.

Parameters:
- DATA_WIDTH, 32, payload width per port.
- FIFO_DEPTH, 2, entries per input FIFO. Must be a power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  2  per-port input valid. Bit 0 is the low port, bit 1 is the high port.
- i_data_bus  input  2*DATA_WIDTH  packed inputs. [0+:DATA_WIDTH] is port 0; [DATA_WIDTH+:DATA_WIDTH] is port 1.
- o_ready  output  2  per-port FIFO not full; write accepted when i_valid[k] and o_ready[k].
- i_en  input  1  arbitration enable; 0 freezes grants.
- o_valid  output  1  output register holds valid data.
- o_data_bus  output  DATA_WIDTH  merged output payload.
- i_ready  input  1  downstream accepts when o_valid and i_ready.

Behaviour:
- Reset (async, rst=1):
  - both FIFOs empty, pointers and counts 0.
  - rr_ptr=0, so port 0 is preferred.
  - o_valid=0, o_data_bus=0.
  - o_ready=2'b00 while rst is high; 2'b11 from the first cycle after release.
- Push: FIFO k is written at the clock edge when i_valid[k] & o_ready[k].
  - o_ready[k] = ~full[k] & ~rst.
  - No write when full, even if a pop occurs in the same cycle (no full bypass).
- Empty bypass: none. Data written at edge t is visible at the FIFO head in cycle t+1.
- Output register load condition: load = i_en & (~o_valid | i_ready) & (nonempty[0] | nonempty[1]).
- Grant rules:
  - If only one FIFO is non-empty, grant it.
  - If both are non-empty, grant rr_ptr.
- On load:
  - pop the granted FIFO.
  - o_data_bus <= granted head; o_valid <= 1.
  - rr_ptr <= ~granted.
- Drain without reload (o_valid & i_ready & ~load): o_valid <= 0, o_data_bus <= 0.
- Hold: when o_valid & ~i_ready, o_data_bus and o_valid are stable and there is no pop.
- Latency and throughput:
  - 2 cycles from input acceptance edge to o_valid at the output, when the path is uncontended.
  - Throughput is one word per cycle with i_ready=1 (load and drain in the same cycle).
- i_en=0:
  - no grants, no pops, rr_ptr frozen.
  - pushes continue.
  - the output register still drains on i_ready.
- Fairness: with both ports continuously non-empty and i_ready=1, outputs alternate 0,1,0,1…
- Simultaneous events:
  - push and pop on the same non-full FIFO in one cycle leaves the count unchanged.
  - wr_ptr and rd_ptr wrap modulo FIFO_DEPTH.
- Reset mid-operation: all buffered data is discarded immediately, with no partial output.
- Count width is $clog2(FIFO_DEPTH)+1; pointer width is $clog2(FIFO_DEPTH).

Decomposition:
- No new shared typedefs are needed.
- Dummy-data constant {DATA_WIDTH{1'b0}} and the port-index convention (0 low, 1 high) live in the shared NoC constants package.
- Sub-module fifo_sync, instantiated twice: parameterised DATA_WIDTH/FIFO_DEPTH, push/pop/full/empty/head, async active-high reset.
- The head select reuses the existing mux_comb2_1 combinational 2:1 mux:
  - i_cmd = grant.
  - i_en = load.
  - i_valid = 1.

Test Plan:
- Reset then single word: port 0 presents 0xA5A5A5A5 at cycle 3 with i_ready=1 -> o_valid=1, o_data_bus=0xA5A5A5A5 at cycle 5, then o_valid=0 and o_data_bus=0.
- Fairness: both ports stream 0x100+n and 0x200+n continuously with i_ready=1 -> output sequence 0x100,0x200,0x101,0x201,…, with no skips or duplicates.
- Backpressure and full:
  - Setup: i_ready=0; port 1 pushes 4 words.
  - Expected: 1 word latched in the output register, FIFO holds 2, o_ready[1]=0.
  - Expected: the 4th word is held off upstream until i_ready=1.
  - Expected: words then emerge in order.
- Arbitration disable: i_en=0 with both FIFOs loaded -> no o_valid rise, rr_ptr unchanged. After i_en=1, port 0 is granted first (post-reset rr_ptr=0).
- Reset mid-stream: assert rst asynchronously mid-cycle with both FIFOs partially full and o_valid=1 -> o_valid, o_data_bus and o_ready go 0 immediately. After release, no stale data appears and o_ready=2'b11.
